mac_fp32_accumulator: RTL and testbench

Accumulation stage of the FP32 MAC datapath, directly downstream of the FP32 multiplier. It takes each product as {sign, exponent, mantissa} and adds it into a running binary32 sum held in an internal accumulator register. Terms enter through a valid/ready handshake, and a completed dot-product sum is presented with a one-cycle `out_valid` pulse. Arithmetic follows the multiplier's conventions: exponent 0 is treated as zero (flush), there is no rounding (truncation), and exponent 255 is saturating.

---
 rtl/mac_fp32_accumulator_pkg.sv | 49 ++++
 rtl/mac_fp32_accumulator_if.sv | 47 ++++
 rtl/mac_fp32_accumulator_lzc.sv | 17 +
 rtl/mac_fp32_accumulator.sv | 216 +++++++++++++++++++++
 tb/tb_mac_fp32_accumulator.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/mac_fp32_accumulator_pkg.sv
// Shared types and constants for the FP32 MAC accumulation stage.
// Format is fixed binary32; no parameters are exposed to users.
package mac_fp32_pkg;

  localparam logic [7:0]   EXP_INF = 8'd255;
  localparam int unsigned  MANT_W  = 23;
  localparam int unsigned  SIG_W   = 24;
  localparam logic [22:0]  QNAN_MANT = 23'h400000;

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM
  } acc_state_t;

  typedef struct packed {
    logic              sign;
    logic [7:0]        exp;
    logic [MANT_W-1:0] mant;
  } fp32_t;

  // Exponent 0 means zero: subnormals are flushed, sign is kept for magnitude compare only.
  function automatic fp32_t flush_zero(fp32_t x);
    fp32_t r;
    r = x;
    if (x.exp == 8'd0) begin
      r.mant = '0;
    end
    return r;
  endfunction

  function automatic fp32_t make_inf(logic sign);
    fp32_t r;
    r.sign = sign;
    r.exp  = EXP_INF;
    r.mant = '0;
    return r;
  endfunction

  function automatic fp32_t make_qnan();
    fp32_t r;
    r.sign = 1'b0;
    r.exp  = EXP_INF;
    r.mant = QNAN_MANT;
    return r;
  endfunction

endpackage

// File: rtl/mac_fp32_accumulator_if.sv
// Term input handshake and published-sum output of the FP32 accumulator.
// master = upstream multiplier / consumer side, slave = the accumulator.
interface mac_fp32_accumulator_if;
  import mac_fp32_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic              in_first;
  logic              in_last;
  logic              prod_sign;
  logic [7:0]        prod_exp;
  logic [MANT_W-1:0] prod_mant;

  logic              out_valid;
  logic              out_sign;
  logic [7:0]        out_exp;
  logic [MANT_W-1:0] out_mant;

  modport master (
    output in_valid,
    output in_first,
    output in_last,
    output prod_sign,
    output prod_exp,
    output prod_mant,
    input  in_ready,
    input  out_valid,
    input  out_sign,
    input  out_exp,
    input  out_mant
  );

  modport slave (
    input  in_valid,
    input  in_first,
    input  in_last,
    input  prod_sign,
    input  prod_exp,
    input  prod_mant,
    output in_ready,
    output out_valid,
    output out_sign,
    output out_exp,
    output out_mant
  );

endinterface

// File: rtl/mac_fp32_accumulator_lzc.sv
// Combinational 25-bit leading-zero counter; an all-zero input yields 25.
module mac_fp32_lzc (
  input  logic [24:0] val_i,
  output logic [4:0]  lz_o
);

  always_comb begin
    lz_o = 5'd25;
    // Ascending scan so the highest set bit is the last (winning) assignment.
    for (int i = 0; i < 25; i++) begin
      if (val_i[i]) begin
        lz_o = 5'(24 - i);
      end
    end
  end

endmodule

// File: rtl/mac_fp32_accumulator.sv
// FP32 running-sum accumulator: IDLE -> ALIGN -> ADD -> NORM, one term per 4 cycles.
// Truncating arithmetic, exponent-0 flush, saturating exponent 255.
module mac_fp32_accumulator
  import mac_fp32_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  mac_fp32_accumulator_if.slave  bus
);

  acc_state_t state_q, state_d;

  fp32_t term_q, term_d;
  fp32_t acc_q, acc_d;
  fp32_t out_q, out_d;
  logic  first_q, first_d;
  logic  last_q, last_d;
  logic  out_valid_q, out_valid_d;

  logic             g_sign_q, g_sign_d;
  logic [7:0]       g_exp_q, g_exp_d;
  logic [SIG_W-1:0] g_sig_q, g_sig_d;
  logic [SIG_W-1:0] l_sig_q, l_sig_d;
  logic             sub_q, sub_d;
  logic             special_q, special_d;
  fp32_t            spec_q, spec_d;
  logic [SIG_W:0]   sum_q, sum_d;

  // ---------------------------------------------------------------------------
  // Alignment datapath (consumed in ALIGN)
  // ---------------------------------------------------------------------------
  fp32_t            op_a, op_b, op_g, op_l;
  logic             a_ge_b;
  logic [7:0]       exp_diff;
  logic [SIG_W-1:0] l_sig_full, l_sig_shifted;
  logic             a_sp, b_sp, a_nan, b_nan;
  logic             align_special;
  fp32_t            align_spec;

  always_comb begin
    op_a          = flush_zero(term_q);
    op_b          = first_q ? fp32_t'('0) : flush_zero(acc_q);
    a_ge_b        = {op_a.exp, op_a.mant} >= {op_b.exp, op_b.mant};
    op_g          = a_ge_b ? op_a : op_b;
    op_l          = a_ge_b ? op_b : op_a;
    exp_diff      = op_g.exp - op_l.exp;
    l_sig_full    = {|op_l.exp, op_l.mant};
    l_sig_shifted = (exp_diff >= 8'd24) ? '0 : (l_sig_full >> exp_diff);
  end

  // A NaN operand propagates as the canonical quiet NaN so a NaN sum survives later terms.
  always_comb begin
    a_sp          = (op_a.exp == EXP_INF);
    b_sp          = (op_b.exp == EXP_INF);
    a_nan         = a_sp && (op_a.mant != '0);
    b_nan         = b_sp && (op_b.mant != '0);
    align_special = a_sp || b_sp;
    align_spec    = '0;
    if (a_sp && b_sp) begin
      if (a_nan || b_nan || (op_a.sign != op_b.sign)) begin
        align_spec = make_qnan();
      end else begin
        align_spec = make_inf(op_a.sign);
      end
    end else if (a_sp) begin
      align_spec = a_nan ? make_qnan() : make_inf(op_a.sign);
    end else if (b_sp) begin
      align_spec = b_nan ? make_qnan() : make_inf(op_b.sign);
    end
  end

  // ---------------------------------------------------------------------------
  // Normalisation datapath (consumed in NORM)
  // ---------------------------------------------------------------------------
  logic [4:0]     lz;
  logic [4:0]     shl;
  logic [8:0]     exp_inc;
  logic [SIG_W:0] norm_sig;
  fp32_t          norm_res;

  mac_fp32_lzc u_lzc (
    .val_i (sum_q),
    .lz_o  (lz)
  );

  // The LZC spans the carry bit, so the hidden bit lands at [23] after a shift of lz-1.
  always_comb begin
    shl      = lz - 5'd1;
    exp_inc  = {1'b0, g_exp_q} + 9'd1;
    norm_sig = sum_q << shl;
    norm_res = '0;
    if (special_q) begin
      norm_res = spec_q;
    end else if (sum_q == '0) begin
      norm_res = '0;
    end else if (sum_q[SIG_W]) begin
      if (exp_inc >= {1'b0, EXP_INF}) begin
        norm_res = make_inf(g_sign_q);
      end else begin
        norm_res.sign = g_sign_q;
        norm_res.exp  = exp_inc[7:0];
        norm_res.mant = sum_q[SIG_W-1:1];
      end
    end else if (g_exp_q <= {3'b000, shl}) begin
      norm_res = '0;
    end else begin
      norm_res.sign = g_sign_q;
      norm_res.exp  = g_exp_q - {3'b000, shl};
      norm_res.mant = norm_sig[MANT_W-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    term_d      = term_q;
    acc_d       = acc_q;
    out_d       = out_q;
    first_d     = first_q;
    last_d      = last_q;
    out_valid_d = 1'b0;
    g_sign_d    = g_sign_q;
    g_exp_d     = g_exp_q;
    g_sig_d     = g_sig_q;
    l_sig_d     = l_sig_q;
    sub_d       = sub_q;
    special_d   = special_q;
    spec_d      = spec_q;
    sum_d       = sum_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          term_d.sign = bus.prod_sign;
          term_d.exp  = bus.prod_exp;
          term_d.mant = bus.prod_mant;
          first_d     = bus.in_first;
          last_d      = bus.in_last;
          state_d     = ALIGN;
        end
      end
      ALIGN: begin
        g_sign_d  = op_g.sign;
        g_exp_d   = op_g.exp;
        g_sig_d   = {|op_g.exp, op_g.mant};
        l_sig_d   = l_sig_shifted;
        sub_d     = op_a.sign ^ op_b.sign;
        special_d = align_special;
        spec_d    = align_spec;
        state_d   = ADD;
      end
      ADD: begin
        // G >= L in magnitude, so the difference cannot go negative.
        if (sub_q) begin
          sum_d = {1'b0, g_sig_q} - {1'b0, l_sig_q};
        end else begin
          sum_d = {1'b0, g_sig_q} + {1'b0, l_sig_q};
        end
        state_d = NORM;
      end
      NORM: begin
        acc_d = norm_res;
        if (last_q) begin
          out_d       = norm_res;
          out_valid_d = 1'b1;
        end
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      term_q      <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      out_valid_q <= 1'b0;
      g_sign_q    <= 1'b0;
      g_exp_q     <= '0;
      g_sig_q     <= '0;
      l_sig_q     <= '0;
      sub_q       <= 1'b0;
      special_q   <= 1'b0;
      spec_q      <= '0;
      sum_q       <= '0;
    end else begin
      state_q     <= state_d;
      term_q      <= term_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      first_q     <= first_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      g_sign_q    <= g_sign_d;
      g_exp_q     <= g_exp_d;
      g_sig_q     <= g_sig_d;
      l_sig_q     <= l_sig_d;
      sub_q       <= sub_d;
      special_q   <= special_d;
      spec_q      <= spec_d;
      sum_q       <= sum_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_sign  = out_q.sign;
  assign bus.out_exp   = out_q.exp;
  assign bus.out_mant  = out_q.mant;

endmodule

// File: tb/tb_mac_fp32_accumulator.sv
// Directed bench for mac_fp32_accumulator with hand-computed binary32 results.
module tb_mac_fp32_accumulator;

  localparam logic [31:0] F_ONE   = 32'h3F80_0000;
  localparam logic [31:0] F_TWO   = 32'h4000_0000;
  localparam logic [31:0] F_THREE = 32'h4040_0000;
  localparam logic [31:0] F_M0P75 = 32'hBF40_0000;
  localparam logic [31:0] F_0P25  = 32'h3E80_0000;
  localparam logic [31:0] F_1P5   = 32'h3FC0_0000;
  localparam logic [31:0] F_M1P5  = 32'hBFC0_0000;
  localparam logic [31:0] F_TINY  = 32'h3080_0000;
  localparam logic [31:0] F_MAX   = 32'h7F7F_FFFF;
  localparam logic [31:0] F_PINF  = 32'h7F80_0000;
  localparam logic [31:0] F_NINF  = 32'hFF80_0000;
  localparam logic [31:0] F_QNAN  = 32'h7FC0_0000;

  logic clk;
  logic rst;
  int   n_run;
  int   n_fail;

  mac_fp32_accumulator_if bus ();

  mac_fp32_accumulator dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] out_word();
    return {bus.out_sign, bus.out_exp, bus.out_mant};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_run++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic set_term(input logic [31:0] t, input logic f, input logic l);
    bus.prod_sign = t[31];
    bus.prod_exp  = t[30:23];
    bus.prod_mant = t[22:0];
    bus.in_first  = f;
    bus.in_last   = l;
  endtask

  // Returns at the falling edge right after the accepting rising edge.
  task automatic send(input logic [31:0] t, input logic f, input logic l);
    for (int i = 0; i < 20 && !bus.in_ready; i++) @(negedge clk);
    check("send_ready", 32'(bus.in_ready), 32'd1);
    set_term(t, f, l);
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    set_term(32'h0, 1'b0, 1'b0);
  endtask

  // Expects the publish pulse 3 falling edges after send() returns, and only one pulse.
  task automatic expect_sum(input string tag, input logic [31:0] exp_v);
    int lat;
    lat = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        lat = i;
        break;
      end
    end
    check({tag, "_lat"}, 32'(lat), 32'd2);
    check(tag, out_word(), exp_v);
    @(negedge clk);
    check({tag, "_pulse"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int acc_cyc [3];
    logic [31:0] terms [3];
    int k;
    int pulses;
    logic just_acc;
    logic [31:0] captured;

    n_run  = 0;
    n_fail = 0;
    rst    = 1'b1;
    bus.in_valid = 1'b0;
    set_term(32'h0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("rst_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out", out_word(), 32'h0);

    // Single term: also check busy window of in_ready.
    send(F_ONE, 1'b1, 1'b1);
    check("busy_ready", 32'(bus.in_ready), 32'd0);
    expect_sum("single_one", F_ONE);

    send(F_ONE, 1'b1, 1'b0);
    send(F_ONE, 1'b0, 1'b1);
    expect_sum("one_plus_one", F_TWO);

    send(F_ONE, 1'b1, 1'b0);
    send(F_M0P75, 1'b0, 1'b1);
    expect_sum("one_minus_0p75", F_0P25);

    send(F_1P5, 1'b1, 1'b0);
    send(F_M1P5, 1'b0, 1'b1);
    expect_sum("cancel", 32'h0);

    send(F_ONE, 1'b1, 1'b0);
    send(F_TINY, 1'b0, 1'b1);
    expect_sum("align_loss", F_ONE);

    send(F_MAX, 1'b1, 1'b0);
    send(F_MAX, 1'b0, 1'b1);
    expect_sum("overflow", F_PINF);

    send(F_PINF, 1'b1, 1'b0);
    send(F_NINF, 1'b0, 1'b1);
    expect_sum("inf_minus_inf", F_QNAN);
    send(F_ONE, 1'b0, 1'b1);
    expect_sum("nan_persists", F_QNAN);

    // in_valid held high across three terms.
    terms[0] = F_ONE;
    terms[1] = F_ONE;
    terms[2] = F_ONE;
    acc_cyc  = '{-1, -1, -1};
    k        = 0;
    pulses   = 0;
    just_acc = 1'b0;
    captured = 32'h0;
    set_term(terms[0], 1'b1, 1'b0);
    bus.in_valid = 1'b1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      if (just_acc) begin
        k++;
        just_acc = 1'b0;
        if (k < 3) begin
          set_term(terms[k], 1'b0, k == 2);
        end else begin
          bus.in_valid = 1'b0;
          set_term(32'h0, 1'b0, 1'b0);
        end
      end
      if (bus.out_valid) begin
        pulses++;
        captured = out_word();
      end
      if (bus.in_valid && bus.in_ready && k < 3) begin
        acc_cyc[k] = cyc;
        just_acc   = 1'b1;
      end
    end
    bus.in_valid = 1'b0;
    check("hs_gap_01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd4);
    check("hs_gap_12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd4);
    check("hs_pulses", 32'(pulses), 32'd1);
    check("hs_sum", captured, F_THREE);

    // Reset while the term sits in ALIGN.
    send(F_ONE, 1'b1, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_out", out_word(), 32'h0);
    check("midrst_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_ready", 32'(bus.in_ready), 32'd1);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.out_valid) pulses++;
    end
    check("midrst_no_pulse", 32'(pulses), 32'd0);
    send(F_TWO, 1'b1, 1'b1);
    expect_sum("after_rst_two", F_TWO);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
